double_tokens: RTL and testbench
================================

# double_tokens

Serial token doubler: every `1` sampled on `a` produces exactly two `1` tokens on `b`, emitted one per cycle as downstream `stall` allows. It is the expanding counterpart of the team's token-halving stage and sits on the same single-bit serial token streams. Undelivered tokens are held in a bounded pending counter. Excess tokens are dropped and flagged on a sticky `overflow` output.

## Interface
- `MAX_PENDING`, default 8: maximum number of tokens held awaiting emission; legal range ≥ 2.
- `CNT_W`, default `$clog2(MAX_PENDING+1)`: width of the pending counter; derived, not overridden.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `a`  in  1  incoming token stream; `1` = one token this cycle.
- `stall`  in  1  downstream back-pressure; while high, no token is emitted.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `b`  out  1  outgoing token stream (registered).
- `pending`  out  CNT_W  tokens accepted but not yet emitted (registered).
- `overflow`  out  1  sticky flag: at least one token was dropped.

## Operation
- Reset value while `rst` is high: `b`=0, `pending`=0, `overflow`=0. Asserting `rst` mid-stream discards all pending tokens immediately.
- Per rising edge, `avail = pending + 2*a`, computed at width CNT_W+2 with no wrap.
- `emit = !stall && avail != 0`.
- Update rule:
  - `b <= emit`.
  - `rem = avail - emit`.
  - If `rem > MAX_PENDING`: `pending <= MAX_PENDING` and `overflow <= 1`.
  - Otherwise `pending <= rem`.
- `overflow` update:
  - `ovf_clr` high on the same edge as a new overflow: set wins, and `overflow` stays 1.
  - `ovf_clr` with no new overflow: `overflow <= 0`.
- `a` is always accepted. There is no input back-pressure.
- Conservation: tokens in × 2 = tokens out + `pending` + tokens dropped.
- No FSM beyond the counter. The two logical states are EMPTY (`pending`=0) and HOLDING (`pending`>0); transitions follow the update rule.

## Timing
- Latency: a token on `a` at edge N makes `b`=1 after edge N (first copy). The second copy follows after edge N+1 if `stall` is low.
- Isolated `a`=1, `stall`=0: `b` is `1,1` on the two cycles following the sample. `pending` reads 1 after the first edge and 0 after the second.
- Continuous `a`=1, `stall`=0: `b` is 1 every cycle and `pending` grows by 1 per cycle.
  - With default `MAX_PENDING`=8, `pending` reaches 8 after 8 edges.
  - The 9th edge computes rem=9 > 8, so `pending` stays 8 and `overflow` rises.
- `stall`=1 with `pending`=0 and `a`=1: `pending` goes to 2 and `b`=0.
- `stall` deassert: emission resumes on the next edge, one token per cycle, until `pending`=0.
- `pending`=MAX_PENDING, `a`=0, `stall`=0: decrements to MAX_PENDING−1 with no overflow.
- `pending`=MAX_PENDING−1, `a`=1, `stall`=1: rem = MAX_PENDING+1, so one token is dropped and `overflow` is set.
- Reset deassertion: first meaningful edge is the first rising edge with `rst` low. No reset-recovery cycles.

## Structure
- Package `token_pkg`:
  - Shared `localparam int TOKEN_W = 1`.
  - Function `sat_sub_add(cur, add, sub, max)` returning the saturated value plus a dropped flag, reused by the halving and doubling stages.
- Sub-module `sat_counter`, instantiated once:
  - Parameterised by MAX and width.
  - Async active-high reset.
  - Inputs: add amount (0..2) and sub (0/1).
  - Outputs: count and a saturation-hit pulse.
- Top level holds the `b` and `overflow` registers and the `emit` logic.

## Test plan
- Reset mid-stream: drive `a`=1 for 3 cycles, assert `rst` asynchronously between edges → `b`, `pending`, `overflow` go to 0 immediately. After release, `a`=0 gives `b`=0 indefinitely.
- Single token: `a` = 1,0,0,0, `stall`=0 → `b` = 0,1,1,0 (one cycle late) and `pending` = 1,0,0.
- Sequence `a` = 110_011_101_000 with `stall`=0 → total `b` ones = 12. The final `pending` reaches 0 within 6 extra cycles. `overflow`=0.
- Stall accumulate: `stall`=1, four `a` pulses → `pending`=8, `b`=0. Release `stall` → exactly 8 consecutive `b`=1, then `pending`=0.
- Overflow: `a`=1, `stall`=0 for 9 cycles → `overflow`=1 after the 9th edge and `pending`=8. Pulse `ovf_clr` with `a`=0 → `overflow`=0.
- Clear/set collision: `pending`=8, `stall`=1, `a`=1 and `ovf_clr`=1 on the same edge → `overflow` stays 1 and `pending`=8.

Source files
------------

// File: rtl/token_pkg.sv
// -----------------------------------------------------------------------------
// token_pkg
// Shared definitions for the single-bit serial token stages (halving and
// doubling). Provides the token stream width and the saturating
// add/subtract helper that both stages use for their pending counters.
// -----------------------------------------------------------------------------
package token_pkg;

    localparam int TOKEN_W = 1;

    // Result of a saturating update: the new count and whether any tokens
    // had to be discarded to stay within the limit.
    typedef struct packed {
        logic [31:0] value;
        logic        dropped;
    } sat_result_t;

    // Computes cur + add - sub without wrapping, then clamps to max.
    // The subtraction is applied before the clamp, so a token emitted on
    // the same edge frees room for an incoming one.
    function automatic sat_result_t sat_sub_add(
        input int unsigned cur,
        input int unsigned add,
        input int unsigned sub,
        input int unsigned max
    );
        sat_result_t res;
        int unsigned rem;
        rem = cur + add - sub;
        if (rem > max) begin
            res.value   = max;
            res.dropped = 1'b1;
        end else begin
            res.value   = rem;
            res.dropped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Bounded pending-token counter. Each edge adds 0..2 and subtracts 0/1;
// the result is clamped to MAX.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears the count
//   add      tokens arriving this cycle (0..2)
//   sub      token leaving this cycle (0/1)
//   count    registered token count
//   sat_hit  high when the update on the coming edge drops tokens
// -----------------------------------------------------------------------------
module sat_counter
    import token_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   add,
    input  logic         sub,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    sat_result_t res;

    always_comb begin
        res = sat_sub_add(32'(count), 32'(add), 32'(sub), MAX);
    end

    // The clamped value never exceeds MAX, so truncating to W bits is safe.
    assign sat_hit = res.dropped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= W'(res.value);
        end
    end

endmodule

// File: rtl/double_tokens.sv
// -----------------------------------------------------------------------------
// double_tokens
// Serial token doubler. Every 1 sampled on a becomes two 1 tokens on b,
// emitted one per cycle while stall is low. Undelivered tokens wait in a
// bounded counter; excess tokens are dropped and flagged on a sticky
// overflow output.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   a        incoming token stream (1 = one token this cycle)
//   stall    downstream back-pressure, blocks emission while high
//   ovf_clr  synchronous clear of overflow (a new overflow wins)
//   b        outgoing token stream (registered)
//   pending  tokens accepted but not yet emitted (registered)
//   overflow sticky flag, at least one token was dropped
// -----------------------------------------------------------------------------
module double_tokens
    import token_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             stall,
    input  logic             ovf_clr,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    logic       emit;
    logic       sat_hit;
    logic [1:0] add_amt;

    // Each input token contributes two output tokens.
    assign add_amt = a ? 2'd2 : 2'd0;

    // A freshly arriving token can be emitted on the same edge it is sampled,
    // so availability includes the current input, not just the stored count.
    assign emit = !stall && (a || (pending != '0));

    sat_counter #(
        .MAX (MAX_PENDING),
        .W   (CNT_W)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .add     (add_amt),
        .sub     (emit),
        .count   (pending),
        .sat_hit (sat_hit)
    );

    // Output token and sticky overflow; a new drop takes priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b        <= 1'b0;
            overflow <= 1'b0;
        end else begin
            b <= emit;
            if (sat_hit) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_double_tokens.sv
// -----------------------------------------------------------------------------
// tb_double_tokens
// Directed self-checking bench for double_tokens with default MAX_PENDING=8.
// -----------------------------------------------------------------------------
module tb_double_tokens;

    logic       clk;
    logic       rst;
    logic       a;
    logic       stall;
    logic       ovf_clr;
    logic       b;
    logic [3:0] pending;
    logic       overflow;

    int vectors;
    int miscompares;

    double_tokens dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .stall    (stall),
        .ovf_clr  (ovf_clr),
        .b        (b),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the edge, and settle just after it.
    task automatic apply_stimulus(input logic a_v, input logic stall_v, input logic clr_v);
        a       = a_v;
        stall   = stall_v;
        ovf_clr = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input int exp_b, input int exp_p, input int exp_o);
        check_output({tag, ".b"}, int'(b), exp_b);
        check_output({tag, ".pending"}, int'(pending), exp_p);
        check_output({tag, ".overflow"}, int'(overflow), exp_o);
    endtask

    int ones;
    int run;
    logic [11:0] seq;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        a       = 1'b0;
        stall   = 1'b0;
        ovf_clr = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0);
        rst = 1'b0;

        // Single isolated token
        apply_stimulus(1, 0, 0);
        check_state("single.e1", 1, 1, 0);
        apply_stimulus(0, 0, 0);
        check_state("single.e2", 1, 0, 0);
        apply_stimulus(0, 0, 0);
        check_state("single.e3", 0, 0, 0);

        // Reset mid-stream: three tokens in, pending 1,2,3
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 0, 0);
        check_state("midrst.pre", 1, 3, 0);
        #2;
        rst = 1'b1;
        #1;
        check_state("midrst.async", 0, 0, 0);
        apply_stimulus(0, 0, 0);
        rst = 1'b0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0);
            ones += int'(b);
        end
        check_output("midrst.idle_b_ones", ones, 0);
        check_output("midrst.idle_pending", int'(pending), 0);

        // Sequence 110_011_101_000, then drain
        seq  = 12'b110_011_101_000;
        ones = 0;
        for (int i = 11; i >= 0; i--) begin
            apply_stimulus(seq[i], 0, 0);
            ones += int'(b);
        end
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 0);
            ones += int'(b);
        end
        check_output("seq.b_ones", ones, 12);
        check_output("seq.pending", int'(pending), 0);
        check_output("seq.overflow", int'(overflow), 0);

        // Stall accumulate: 4 tokens -> 8 pending, no output
        apply_stimulus(1, 1, 0);
        check_state("stall.e1", 0, 2, 0);
        apply_stimulus(1, 1, 0);
        apply_stimulus(1, 1, 0);
        apply_stimulus(1, 1, 0);
        check_state("stall.e4", 0, 8, 0);
        run = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 0);
            if (b) run++;
        end
        check_output("stall.release_run", run, 8);
        check_output("stall.drained", int'(pending), 0);
        apply_stimulus(0, 0, 0);
        check_output("stall.after_b", int'(b), 0);

        // Overflow by continuous input
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 0, 0);
        end
        check_state("ovf.e8", 1, 8, 0);
        apply_stimulus(1, 0, 0);
        check_state("ovf.e9", 1, 8, 1);
        apply_stimulus(0, 0, 1);
        check_state("ovf.clr", 1, 7, 0);

        // pending = MAX-1, a=1, stall=1 drops one token
        apply_stimulus(1, 1, 0);
        check_state("ovf.max_m1", 0, 8, 1);

        // Clear/set collision: set wins
        apply_stimulus(1, 1, 1);
        check_state("collide", 0, 8, 1);
        apply_stimulus(0, 1, 1);
        check_state("collide.clr", 0, 8, 0);

        // From MAX with a=0, stall=0: plain decrement
        apply_stimulus(0, 0, 0);
        check_state("max.dec", 1, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
